// File: rtl/lookup_input_arbiter_pkg.sv
// Shared definitions for the lookup input arbiter: FSM encoding and source indices.
package lookup_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PKT0 = 2'd1,
        ARB_PKT1 = 2'd2
    } arb_state_t;

    localparam logic SRC_RX  = 1'b0;
    localparam logic SRC_CPU = 1'b1;

endpackage

// File: rtl/lookup_input_arbiter.sv
// Packet-atomic 2:1 AXI-Stream arbiter feeding the output-port-lookup stage.
// RX (source 0) and CPU (source 1) share one zero-latency combinational path.
module lookup_input_arbiter
    import lookup_arb_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESET,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    S0_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S0_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S0_AXIS_TUSER,
    input  logic                            S0_AXIS_TVALID,
    input  logic                            S0_AXIS_TLAST,
    output logic                            S0_AXIS_TREADY,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    S1_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S1_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S1_AXIS_TUSER,
    input  logic                            S1_AXIS_TVALID,
    input  logic                            S1_AXIS_TLAST,
    output logic                            S1_AXIS_TREADY,

    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,

    input  logic                            cfg_strict_prio,
    input  logic                            cnt_clear,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   pkt_count0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   pkt_count1
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_grant;
    logic       sel;
    logic       active;
    logic       sel_valid;
    logic       sel_last;
    logic       m_hs;

    // Grant selection: re-decided every IDLE cycle until the first beat is taken.
    always_comb begin
        sel    = SRC_RX;
        active = 1'b0;
        case (state)
            ARB_IDLE: begin
                active = S0_AXIS_TVALID | S1_AXIS_TVALID;
                if (S0_AXIS_TVALID && S1_AXIS_TVALID)
                    sel = cfg_strict_prio ? SRC_CPU : ~last_grant;
                else if (S1_AXIS_TVALID)
                    sel = SRC_CPU;
            end
            ARB_PKT0: begin
                active = 1'b1;
                sel    = SRC_RX;
            end
            ARB_PKT1: begin
                active = 1'b1;
                sel    = SRC_CPU;
            end
            default: begin
                active = 1'b0;
                sel    = SRC_RX;
            end
        endcase
    end

    assign sel_valid = (sel == SRC_CPU) ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    assign sel_last  = (sel == SRC_CPU) ? S1_AXIS_TLAST  : S0_AXIS_TLAST;

    assign M_AXIS_TDATA  = (sel == SRC_CPU) ? S1_AXIS_TDATA : S0_AXIS_TDATA;
    assign M_AXIS_TSTRB  = (sel == SRC_CPU) ? S1_AXIS_TSTRB : S0_AXIS_TSTRB;
    assign M_AXIS_TUSER  = (sel == SRC_CPU) ? S1_AXIS_TUSER : S0_AXIS_TUSER;
    assign M_AXIS_TLAST  = sel_last;
    assign M_AXIS_TVALID = ~AXI_RESET & active & sel_valid;

    assign S0_AXIS_TREADY = ~AXI_RESET & active & (sel == SRC_RX)  & M_AXIS_TREADY;
    assign S1_AXIS_TREADY = ~AXI_RESET & active & (sel == SRC_CPU) & M_AXIS_TREADY;

    assign m_hs = M_AXIS_TVALID & M_AXIS_TREADY;

    // A single-beat packet never leaves IDLE; longer ones lock until TLAST.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (m_hs && !sel_last)
                    state_next = (sel == SRC_CPU) ? ARB_PKT1 : ARB_PKT0;
            end
            ARB_PKT0, ARB_PKT1: begin
                if (m_hs && sel_last)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state      <= ARB_IDLE;
            last_grant <= SRC_CPU;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && m_hs)
                last_grant <= sel;
        end
    end

    // Clear wins over a same-cycle TLAST increment.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET || cnt_clear) begin
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else if (m_hs && sel_last) begin
            if (sel == SRC_RX)
                pkt_count0 <= pkt_count0 + C_S_AXI_DATA_WIDTH'(1);
            else
                pkt_count1 <= pkt_count1 + C_S_AXI_DATA_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_lookup_input_arbiter.sv
// Directed testbench for lookup_input_arbiter: per-scenario tasks with inline checks.
// Sources are modelled as packet generators that advance on their own handshakes.
module tb_lookup_input_arbiter;
    import lookup_arb_pkg::*;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            AXI_RESET;
    logic [DW-1:0]   S0_AXIS_TDATA, S1_AXIS_TDATA, M_AXIS_TDATA;
    logic [DW/8-1:0] S0_AXIS_TSTRB, S1_AXIS_TSTRB, M_AXIS_TSTRB;
    logic [UW-1:0]   S0_AXIS_TUSER, S1_AXIS_TUSER, M_AXIS_TUSER;
    logic            S0_AXIS_TVALID, S1_AXIS_TVALID, M_AXIS_TVALID;
    logic            S0_AXIS_TLAST, S1_AXIS_TLAST, M_AXIS_TLAST;
    logic            S0_AXIS_TREADY, S1_AXIS_TREADY, M_AXIS_TREADY;
    logic            cfg_strict_prio, cnt_clear;
    logic [CW-1:0]   pkt_count0, pkt_count1;

    always #5 clk = ~clk;

    lookup_input_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_S_AXI_DATA_WIDTH(CW)
    ) dut (
        .AXI_ACLK       (clk),
        .AXI_RESET      (AXI_RESET),
        .S0_AXIS_TDATA  (S0_AXIS_TDATA),
        .S0_AXIS_TSTRB  (S0_AXIS_TSTRB),
        .S0_AXIS_TUSER  (S0_AXIS_TUSER),
        .S0_AXIS_TVALID (S0_AXIS_TVALID),
        .S0_AXIS_TLAST  (S0_AXIS_TLAST),
        .S0_AXIS_TREADY (S0_AXIS_TREADY),
        .S1_AXIS_TDATA  (S1_AXIS_TDATA),
        .S1_AXIS_TSTRB  (S1_AXIS_TSTRB),
        .S1_AXIS_TUSER  (S1_AXIS_TUSER),
        .S1_AXIS_TVALID (S1_AXIS_TVALID),
        .S1_AXIS_TLAST  (S1_AXIS_TLAST),
        .S1_AXIS_TREADY (S1_AXIS_TREADY),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TSTRB   (M_AXIS_TSTRB),
        .M_AXIS_TUSER   (M_AXIS_TUSER),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .M_AXIS_TREADY  (M_AXIS_TREADY),
        .cfg_strict_prio(cfg_strict_prio),
        .cnt_clear      (cnt_clear),
        .pkt_count0     (pkt_count0),
        .pkt_count1     (pkt_count1)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Source generator state, index 0 = RX, 1 = CPU
    int s_len  [2];
    int s_left [2];
    int s_beat [2];
    int s_pkt  [2];

    // Output log entry: {tlast, src, pkt[7:0], beat[7:0]}
    logic [17:0] out_log[$];
    logic        obs_mvalid, obs_s0r, obs_s1r;
    logic [UW-1:0] obs_user;

    task automatic load_src(input int i, input int npkts, input int len);
        s_left[i] = npkts;
        s_len[i]  = len;
        s_beat[i] = 0;
        s_pkt[i]  = 0;
    endtask

    task automatic drive_sources();
        S0_AXIS_TVALID = (s_left[0] > 0);
        S0_AXIS_TDATA  = '0;
        S0_AXIS_TDATA[16:0] = {1'b0, 8'(s_pkt[0]), 8'(s_beat[0])};
        S0_AXIS_TSTRB  = '1;
        S0_AXIS_TUSER  = '0;
        S0_AXIS_TUSER[7:0] = 8'hA0 + 8'(s_beat[0]);
        S0_AXIS_TLAST  = (s_beat[0] == s_len[0] - 1);
        S1_AXIS_TVALID = (s_left[1] > 0);
        S1_AXIS_TDATA  = '0;
        S1_AXIS_TDATA[16:0] = {1'b1, 8'(s_pkt[1]), 8'(s_beat[1])};
        S1_AXIS_TSTRB  = '1;
        S1_AXIS_TUSER  = '0;
        S1_AXIS_TUSER[7:0] = 8'hB0 + 8'(s_beat[1]);
        S1_AXIS_TLAST  = (s_beat[1] == s_len[1] - 1);
    endtask

    task automatic advance(input int i, input logic hs);
        if (hs) begin
            if (s_beat[i] == s_len[i] - 1) begin
                s_beat[i] = 0;
                s_pkt[i]  = s_pkt[i] + 1;
                s_left[i] = s_left[i] - 1;
            end else begin
                s_beat[i] = s_beat[i] + 1;
            end
        end
    endtask

    // One clock: drive at negedge, sample mid-cycle, commit at posedge.
    task automatic step();
        logic hs0, hs1;
        @(negedge clk);
        drive_sources();
        #1;
        obs_mvalid = M_AXIS_TVALID;
        obs_s0r    = S0_AXIS_TREADY;
        obs_s1r    = S1_AXIS_TREADY;
        obs_user   = M_AXIS_TUSER;
        hs0 = S0_AXIS_TVALID & S0_AXIS_TREADY;
        hs1 = S1_AXIS_TVALID & S1_AXIS_TREADY;
        if (M_AXIS_TVALID && M_AXIS_TREADY)
            out_log.push_back({M_AXIS_TLAST, M_AXIS_TDATA[16:0]});
        @(posedge clk);
        advance(0, hs0);
        advance(1, hs1);
        #1;
    endtask

    task automatic apply_reset();
        AXI_RESET = 1'b1;
        load_src(0, 0, 1);
        load_src(1, 0, 1);
        step();
        step();
        AXI_RESET = 1'b0;
        out_log.delete();
    endtask

    function automatic logic [17:0] log_at(input int i);
        if (i < out_log.size())
            return out_log[i];
        return 18'h3FFFF;
    endfunction

    task automatic test_reset();
        AXI_RESET = 1'b1;
        M_AXIS_TREADY = 1'b1;
        load_src(0, 1, 2);
        load_src(1, 1, 2);
        step();
        total_cnt++;
        if (obs_mvalid !== 1'b0) $display("[TB] FAIL reset_mvalid got=%b exp=0", obs_mvalid);
        else pass_cnt++;
        total_cnt++;
        if (obs_s0r !== 1'b0 || obs_s1r !== 1'b0)
            $display("[TB] FAIL reset_tready got=%b%b exp=00", obs_s0r, obs_s1r);
        else pass_cnt++;
        step();
        total_cnt++;
        if (pkt_count0 !== '0 || pkt_count1 !== '0)
            $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", pkt_count0, pkt_count1);
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== ARB_IDLE) $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.state, ARB_IDLE);
        else pass_cnt++;
        AXI_RESET = 1'b0;
        load_src(0, 0, 1);
        load_src(1, 0, 1);
        out_log.delete();
    endtask

    task automatic test_single_source();
        logic          s1_seen = 1'b0;
        logic [UW-1:0] first_user = '0;
        logic [UW-1:0] exp_user = '0;
        apply_reset();
        M_AXIS_TREADY = 1'b1;
        load_src(0, 1, 3);
        for (int k = 0; k < 3; k++) begin
            step();
            if (obs_s1r) s1_seen = 1'b1;
            if (k == 0) first_user = obs_user;
        end
        exp_user[7:0] = 8'hA0;
        total_cnt++;
        if (s1_seen !== 1'b0) $display("[TB] FAIL single_s1_ready got=1 exp=0");
        else pass_cnt++;
        total_cnt++;
        if (out_log.size() != 3) $display("[TB] FAIL single_beats got=%0d exp=3", out_log.size());
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (log_at(i) !== {1'(i == 2), 1'b0, 8'd0, 8'(i)})
                $display("[TB] FAIL single_beat%0d got=%h exp=%h", i, log_at(i), {1'(i == 2), 1'b0, 8'd0, 8'(i)});
            else pass_cnt++;
        end
        total_cnt++;
        if (first_user !== exp_user) $display("[TB] FAIL single_tuser got=%h exp=%h", first_user[7:0], exp_user[7:0]);
        else pass_cnt++;
        total_cnt++;
        if (pkt_count0 !== 32'd1) $display("[TB] FAIL single_count0 got=%0d exp=1", pkt_count0);
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs_mvalid !== 1'b0 || obs_s0r !== 1'b0) $display("[TB] FAIL single_idle got=%b%b exp=00", obs_mvalid, obs_s0r);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [17:0] e;
        apply_reset();
        M_AXIS_TREADY = 1'b1;
        load_src(0, 2, 2);
        load_src(1, 2, 2);
        repeat (8) step();
        total_cnt++;
        if (out_log.size() != 8) $display("[TB] FAIL rr_beats got=%0d exp=8", out_log.size());
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            e = {1'(i % 2 == 1), 1'((i / 2) % 2), 8'(i / 4), 8'(i % 2)};
            total_cnt++;
            if (log_at(i) !== e) $display("[TB] FAIL rr_beat%0d got=%h exp=%h", i, log_at(i), e);
            else pass_cnt++;
        end
        total_cnt++;
        if (pkt_count0 !== 32'd2 || pkt_count1 !== 32'd2)
            $display("[TB] FAIL rr_counts got=%0d/%0d exp=2/2", pkt_count0, pkt_count1);
        else pass_cnt++;
    endtask

    task automatic test_strict();
        apply_reset();
        M_AXIS_TREADY = 1'b1;
        cfg_strict_prio = 1'b1;
        load_src(0, 5, 2);
        load_src(1, 4, 2);
        repeat (8) step();
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (log_at(i) !== {1'(i % 2 == 1), 1'b1, 8'(i / 2), 8'(i % 2)})
                $display("[TB] FAIL strict_beat%0d got=%h exp=%h", i, log_at(i), {1'(i % 2 == 1), 1'b1, 8'(i / 2), 8'(i % 2)});
            else pass_cnt++;
        end
        total_cnt++;
        if (pkt_count0 !== 32'd0 || pkt_count1 !== 32'd4)
            $display("[TB] FAIL strict_counts got=%0d/%0d exp=0/4", pkt_count0, pkt_count1);
        else pass_cnt++;
        cfg_strict_prio = 1'b0;
        s_left[1] = 2;
        repeat (2) step();
        total_cnt++;
        if (log_at(8) !== {1'b0, 1'b0, 8'd0, 8'd0} || log_at(9) !== {1'b1, 1'b0, 8'd0, 8'd1})
            $display("[TB] FAIL strict_off_src got=%h,%h exp=00000,20001", log_at(8), log_at(9));
        else pass_cnt++;
        total_cnt++;
        if (pkt_count0 !== 32'd1) $display("[TB] FAIL strict_off_count0 got=%0d exp=1", pkt_count0);
        else pass_cnt++;
    endtask

    task automatic test_lock_toggle();
        logic s1_bad = 1'b0;
        logic hold_bad = 1'b0;
        logic [17:0] e;
        apply_reset();
        M_AXIS_TREADY = 1'b1;
        load_src(0, 1, 5);
        load_src(1, 0, 2);
        step();
        load_src(1, 1, 2);
        for (int k = 0; k < 8; k++) begin
            M_AXIS_TREADY = (k % 2 == 1);
            step();
            if (obs_s1r) s1_bad = 1'b1;
            if (k % 2 == 0 && !obs_mvalid) hold_bad = 1'b1;
        end
        M_AXIS_TREADY = 1'b1;
        repeat (2) step();
        total_cnt++;
        if (s1_bad !== 1'b0) $display("[TB] FAIL lock_s1_ready got=1 exp=0");
        else pass_cnt++;
        total_cnt++;
        if (hold_bad !== 1'b0) $display("[TB] FAIL lock_valid_hold got=0 exp=1");
        else pass_cnt++;
        total_cnt++;
        if (out_log.size() != 7) $display("[TB] FAIL lock_beats got=%0d exp=7", out_log.size());
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            e = (i < 5) ? {1'(i == 4), 1'b0, 8'd0, 8'(i)} : {1'(i == 6), 1'b1, 8'd0, 8'(i - 5)};
            total_cnt++;
            if (log_at(i) !== e) $display("[TB] FAIL lock_beat%0d got=%h exp=%h", i, log_at(i), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_counters();
        apply_reset();
        M_AXIS_TREADY = 1'b1;
        @(negedge clk);
        force dut.pkt_count0 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.pkt_count0;
        load_src(0, 1, 1);
        step();
        total_cnt++;
        if (pkt_count0 !== 32'd0) $display("[TB] FAIL wrap_count0 got=%h exp=00000000", pkt_count0);
        else pass_cnt++;
        load_src(1, 1, 1);
        step();
        total_cnt++;
        if (pkt_count1 !== 32'd1) $display("[TB] FAIL pre_clear_count1 got=%0d exp=1", pkt_count1);
        else pass_cnt++;
        load_src(1, 1, 1);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        total_cnt++;
        if (pkt_count1 !== 32'd0) $display("[TB] FAIL clear_vs_inc got=%0d exp=0", pkt_count1);
        else pass_cnt++;
        load_src(0, 1, 1);
        step();
        total_cnt++;
        if (pkt_count0 !== 32'd1 || pkt_count1 !== 32'd0)
            $display("[TB] FAIL post_clear_counts got=%0d/%0d exp=1/0", pkt_count0, pkt_count1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        M_AXIS_TREADY = 1'b1;
        load_src(1, 1, 1);
        step();
        total_cnt++;
        if (pkt_count1 !== 32'd1) $display("[TB] FAIL midrst_pre_count1 got=%0d exp=1", pkt_count1);
        else pass_cnt++;
        load_src(0, 1, 4);
        repeat (2) step();
        AXI_RESET = 1'b1;
        step();
        total_cnt++;
        if (obs_s0r !== 1'b0 || obs_mvalid !== 1'b0)
            $display("[TB] FAIL midrst_outputs got=%b%b exp=00", obs_s0r, obs_mvalid);
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== ARB_IDLE) $display("[TB] FAIL midrst_state got=%0d exp=%0d", dut.state, ARB_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (pkt_count0 !== '0 || pkt_count1 !== '0)
            $display("[TB] FAIL midrst_counts got=%0d/%0d exp=0/0", pkt_count0, pkt_count1);
        else pass_cnt++;
        AXI_RESET = 1'b0;
        s_left[0] = 0;
        out_log.delete();
        load_src(1, 1, 2);
        repeat (2) step();
        total_cnt++;
        if (log_at(0) !== {1'b0, 1'b1, 8'd0, 8'd0} || log_at(1) !== {1'b1, 1'b1, 8'd0, 8'd1} || out_log.size() != 2)
            $display("[TB] FAIL midrst_s1_pkt got=%h,%h exp=10000,30001", log_at(0), log_at(1));
        else pass_cnt++;
        total_cnt++;
        if (pkt_count1 !== 32'd1 || pkt_count0 !== 32'd0)
            $display("[TB] FAIL midrst_post_counts got=%0d/%0d exp=0/1", pkt_count0, pkt_count1);
        else pass_cnt++;
    endtask

    initial begin
        AXI_RESET       = 1'b1;
        M_AXIS_TREADY   = 1'b0;
        cfg_strict_prio = 1'b0;
        cnt_clear       = 1'b0;
        load_src(0, 0, 1);
        load_src(1, 0, 1);
        drive_sources();
        test_reset();
        test_single_source();
        test_round_robin();
        test_strict();
        test_lock_toggle();
        test_counters();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
